// File: rtl/ascii_time_sender_pkg.sv
// Shared UART definitions: ASCII constants, decoder command codes and the
// state encoding of the time-report transmitter.
package ascii_time_sender_pkg;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Receive-side command bytes, kept here so both directions share one table
    localparam logic [7:0] CMD_R = 8'h72;
    localparam logic [7:0] CMD_L = 8'h6C;
    localparam logic [7:0] CMD_U = 8'h75;
    localparam logic [7:0] CMD_D = 8'h64;
    localparam logic [7:0] CMD_0 = 8'h30;
    localparam logic [7:0] CMD_1 = 8'h31;
    localparam logic [7:0] CMD_2 = 8'h32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOAD    = 2'd1;
    localparam logic [1:0] ST_WAIT_HI = 2'd2;
    localparam logic [1:0] ST_WAIT_LO = 2'd3;

    // Last count value of the lost-busy-edge guard (four low cycles)
    localparam logic [2:0] BUSY_TIMEOUT_LAST = 3'd3;

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_0 + {4'h0, digit};
    endfunction

endpackage

// File: rtl/ascii_time_sender_bin2ascii_2digit.sv
// Two-digit decimal to ASCII converter; values above 99 saturate to "99".
module bin2ascii_2digit
    import ascii_time_sender_pkg::*;
(
    input  logic [6:0] value,
    output logic [7:0] tens,
    output logic [7:0] ones
);

    logic [6:0] sat_s;
    logic [3:0] tens_v_s;
    logic [3:0] ones_v_s;

    // Saturate, split into decimal digits and encode as ASCII
    always_comb begin
        if (value > 7'd99) begin
            sat_s = 7'd99;
        end else begin
            sat_s = value;
        end
        tens_v_s = 4'(sat_s / 7'd10);
        ones_v_s = 4'(sat_s % 7'd10);
        tens     = digit_to_ascii(tens_v_s);
        ones     = digit_to_ascii(ones_v_s);
    end

endmodule

// File: rtl/ascii_time_sender.sv
// Snapshots the time on request and streams "HH:MM:SS.CC" plus line
// terminator to uart_tx over a start/busy handshake.
module ascii_time_sender
    import ascii_time_sender_pkg::*;
#(
    parameter bit CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_req,
    input  logic [4:0] i_hour,
    input  logic [5:0] i_min,
    input  logic [5:0] i_sec,
    input  logic [6:0] i_msec,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       sending
);

    localparam logic [3:0] LAST_IDX = CRLF ? 4'd12 : 4'd11;

    logic [1:0] state_r;
    logic [3:0] idx_r;
    logic       pending_r;
    logic [2:0] to_cnt_r;
    logic [4:0] hour_r;
    logic [5:0] min_r;
    logic [5:0] sec_r;
    logic [6:0] cs_r;

    logic [7:0] hour_t_s, hour_o_s, min_t_s, min_o_s;
    logic [7:0] sec_t_s, sec_o_s, cs_t_s, cs_o_s;
    logic [7:0] byte_s;

    bin2ascii_2digit u_hour (.value({2'b00, hour_r}), .tens(hour_t_s), .ones(hour_o_s));
    bin2ascii_2digit u_min  (.value({1'b0, min_r}),   .tens(min_t_s),  .ones(min_o_s));
    bin2ascii_2digit u_sec  (.value({1'b0, sec_r}),   .tens(sec_t_s),  .ones(sec_o_s));
    bin2ascii_2digit u_cs   (.value(cs_r),            .tens(cs_t_s),   .ones(cs_o_s));

    // Select the frame byte addressed by the current index
    always_comb begin
        case (idx_r)
            4'd0:    byte_s = hour_t_s;
            4'd1:    byte_s = hour_o_s;
            4'd2:    byte_s = ASCII_COLON;
            4'd3:    byte_s = min_t_s;
            4'd4:    byte_s = min_o_s;
            4'd5:    byte_s = ASCII_COLON;
            4'd6:    byte_s = sec_t_s;
            4'd7:    byte_s = sec_o_s;
            4'd8:    byte_s = ASCII_DOT;
            4'd9:    byte_s = cs_t_s;
            4'd10:   byte_s = cs_o_s;
            4'd11:   byte_s = CRLF ? ASCII_CR : ASCII_LF;
            4'd12:   byte_s = ASCII_LF;
            default: byte_s = 8'h00;
        endcase
    end

    // Frame sequencer, snapshot registers and single-deep request queue
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= 4'd0;
            pending_r <= 1'b0;
            to_cnt_r  <= 3'd0;
            hour_r    <= 5'd0;
            min_r     <= 6'd0;
            sec_r     <= 6'd0;
            cs_r      <= 7'd0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
            sending   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            // A request arriving mid-frame (even on the final busy fall) is queued
            if (send_req && (state_r != ST_IDLE)) begin
                pending_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (send_req || pending_r) begin
                        hour_r    <= i_hour;
                        min_r     <= i_min;
                        sec_r     <= i_sec;
                        cs_r      <= i_msec;
                        pending_r <= 1'b0;
                        sending   <= 1'b1;
                        idx_r     <= 4'd0;
                        state_r   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!tx_busy) begin
                        tx_data  <= byte_s;
                        tx_start <= 1'b1;
                        to_cnt_r <= 3'd0;
                        state_r  <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    if (tx_busy || (to_cnt_r == BUSY_TIMEOUT_LAST)) begin
                        state_r <= ST_WAIT_LO;
                    end else begin
                        to_cnt_r <= to_cnt_r + 3'd1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (idx_r == LAST_IDX) begin
                            sending <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            idx_r   <= idx_r + 4'd1;
                            state_r <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_time_sender.sv
// Randomised and directed bench for ascii_time_sender (CRLF and LF-only builds)
// against an arithmetic frame model and a busy-for-10-cycles uart_tx model.
module tb_ascii_time_sender;

    typedef byte unsigned bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       send_req_13, send_req_12;
    logic [4:0] i_hour;
    logic [5:0] i_min, i_sec;
    logic [6:0] i_msec;
    logic       busy_13, busy_12, start_13, start_12, sending_13, sending_12;
    logic [7:0] data_13, data_12;

    int  busy_cnt_13 = 0;
    int  busy_cnt_12 = 0;
    bit  no_busy;
    bit  skip_fall;
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    bq_t q_13, q_12, exp_13, exp_12, exp_all;
    int  start_cyc_13[$];
    int  rises_13 = 0;
    int  fall_cyc_13 = 0;
    int  gap_13 = 0;
    bit  prev_send_13 = 1'b0;
    bit  prev_send_12 = 1'b0;

    ascii_time_sender #(.CRLF(1'b1)) u_dut13 (
        .clk(clk), .rst(rst), .send_req(send_req_13),
        .i_hour(i_hour), .i_min(i_min), .i_sec(i_sec), .i_msec(i_msec),
        .tx_busy(busy_13), .tx_start(start_13), .tx_data(data_13), .sending(sending_13)
    );

    ascii_time_sender #(.CRLF(1'b0)) u_dut12 (
        .clk(clk), .rst(rst), .send_req(send_req_12),
        .i_hour(i_hour), .i_min(i_min), .i_sec(i_sec), .i_msec(i_msec),
        .tx_busy(busy_12), .tx_start(start_12), .tx_data(data_12), .sending(sending_12)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counter and uart_tx models (busy for 10 cycles after each start)
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (start_13 && !no_busy) busy_cnt_13 <= 10;
        else if (busy_cnt_13 != 0) busy_cnt_13 <= busy_cnt_13 - 1;
        if (start_12 && !no_busy) busy_cnt_12 <= 10;
        else if (busy_cnt_12 != 0) busy_cnt_12 <= busy_cnt_12 - 1;
    end
    assign busy_13 = (busy_cnt_13 != 0);
    assign busy_12 = (busy_cnt_12 != 0);

    // Byte capture and handshake monitors
    always @(negedge clk) begin
        if (start_13) begin
            q_13.push_back(data_13);
            start_cyc_13.push_back(cyc);
            check_val("start_while_busy13", 32'(busy_13), 32'd0);
        end
        if (start_12) begin
            q_12.push_back(data_12);
            check_val("start_while_busy12", 32'(busy_12), 32'd0);
        end
        if (sending_13 && !prev_send_13) begin
            rises_13 <= rises_13 + 1;
            gap_13   <= cyc - fall_cyc_13;
        end
        if (!sending_13 && prev_send_13) begin
            fall_cyc_13 <= cyc;
            if (!skip_fall) check_val("fall_before_busy13", 32'(busy_13), 32'd0);
        end
        if (!sending_12 && prev_send_12 && !skip_fall)
            check_val("fall_before_busy12", 32'(busy_12), 32'd0);
        prev_send_13 <= sending_13;
        prev_send_12 <= sending_12;
    end

    // Reference frame: two decimal digits per field, saturated at 99
    task automatic make_expected(input int h, input int m, input int s, input int c);
        int f[4];
        int v;
        f[0] = h; f[1] = m; f[2] = s; f[3] = c;
        exp_13.delete();
        for (int k = 0; k < 4; k++) begin
            v = (f[k] > 99) ? 99 : f[k];
            exp_13.push_back(8'(48 + v / 10));
            exp_13.push_back(8'(48 + v % 10));
            if (k < 2) exp_13.push_back(8'h3A);
            else if (k == 2) exp_13.push_back(8'h2E);
        end
        exp_12 = exp_13;
        exp_12.push_back(8'h0A);
        exp_13.push_back(8'h0D);
        exp_13.push_back(8'h0A);
    endtask

    task automatic compare_q(input string tag, input bq_t got, input bq_t exp);
        check_val($sformatf("%s_len", tag), 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check_val($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic set_time(input int h, input int m, input int s, input int c);
        i_hour = 5'(h); i_min = 6'(m); i_sec = 6'(s); i_msec = 7'(c);
    endtask

    task automatic pulse_req(input bit a, input bit b);
        @(posedge clk); #1;
        send_req_13 = a; send_req_12 = b;
        @(posedge clk); #1;
        send_req_13 = 1'b0; send_req_12 = 1'b0;
    endtask

    task automatic clear_caps();
        q_13.delete(); q_12.delete(); start_cyc_13.delete();
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        int quiet = 0;
        while (quiet < 5 && n < budget) begin
            @(negedge clk);
            n++;
            if (!sending_13 && !sending_12 && !busy_13 && !busy_12) quiet++;
            else quiet = 0;
        end
        check_val("quiet_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_bytes13(input int k, input int budget);
        int n = 0;
        while (q_13.size() < k && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("bytes_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_busy13(input bit level, input int budget);
        int n = 0;
        while (busy_13 != level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("busy_timeout", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int sz13, sz12, r0;
        int h, m, s, c;
        rst = 1'b1; send_req_13 = 1'b0; send_req_12 = 1'b0;
        no_busy = 1'b0; skip_fall = 1'b0;
        set_time(0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_start", 32'(start_13), 32'd0);
        check_val("rst_data", 32'(data_13), 32'd0);
        check_val("rst_sending", 32'(sending_13), 32'd0);
        check_val("rst_sending12", 32'(sending_12), 32'd0);
        rst = 1'b0;

        // 12:34:56.78 with first-byte latency
        clear_caps();
        set_time(12, 34, 56, 78);
        make_expected(12, 34, 56, 78);
        pulse_req(1'b1, 1'b1);
        check_val("latency_early", 32'(start_13), 32'd0);
        check_val("sending_rise", 32'(sending_13), 32'd1);
        @(posedge clk); #1;
        check_val("latency_2cyc", 32'(start_13), 32'd1);
        check_val("first_byte", 32'(data_13), 32'h31);
        wait_quiet(1000);
        compare_q("f13_a", q_13, exp_13);
        compare_q("f12_a", q_12, exp_12);

        // All-zero time
        clear_caps();
        set_time(0, 0, 0, 0);
        make_expected(0, 0, 0, 0);
        pulse_req(1'b1, 1'b1);
        wait_quiet(1000);
        compare_q("f13_zero", q_13, exp_13);
        compare_q("f12_zero", q_12, exp_12);

        // Saturation and snapshot hold
        clear_caps();
        set_time(7, 8, 5, 120);
        make_expected(7, 8, 5, 120);
        pulse_req(1'b1, 1'b1);
        set_time(9, 9, 6, 3);
        wait_quiet(1000);
        compare_q("f13_sat", q_13, exp_13);
        compare_q("f12_sat", q_12, exp_12);

        // Two requests mid-frame, one on the final busy fall: exactly one extra frame
        clear_caps();
        r0 = rises_13;
        set_time(1, 2, 3, 4);
        make_expected(1, 2, 3, 4);
        exp_all = exp_13;
        pulse_req(1'b1, 1'b0);
        wait_bytes13(3, 200);
        pulse_req(1'b1, 1'b0);
        set_time(22, 59, 58, 97);
        make_expected(22, 59, 58, 97);
        exp_all = {exp_all, exp_13};
        wait_bytes13(13, 400);
        wait_busy13(1'b1, 50);
        wait_busy13(1'b0, 50);
        send_req_13 = 1'b1;
        @(posedge clk); #1;
        send_req_13 = 1'b0;
        wait_quiet(1000);
        repeat (40) @(negedge clk);
        compare_q("f13_pend", q_13, exp_all);
        check_val("pend_frames", 32'(rises_13 - r0), 32'd2);
        check_val("pend_gap", 32'(gap_13), 32'd1);

        // Reset during byte 5 drops the frame and the pending request
        clear_caps();
        set_time(3, 4, 5, 6);
        pulse_req(1'b1, 1'b1);
        wait_bytes13(2, 200);
        pulse_req(1'b1, 1'b1);
        wait_bytes13(6, 400);
        skip_fall = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("mid_rst_start", 32'(start_13), 32'd0);
        check_val("mid_rst_sending", 32'(sending_13), 32'd0);
        check_val("mid_rst_data", 32'(data_13), 32'd0);
        check_val("mid_rst_sending12", 32'(sending_12), 32'd0);
        rst = 1'b0;
        sz13 = q_13.size();
        sz12 = q_12.size();
        repeat (40) @(negedge clk);
        check_val("no_pending13", 32'(q_13.size()), 32'(sz13));
        check_val("no_pending12", 32'(q_12.size()), 32'(sz12));
        skip_fall = 1'b0;
        clear_caps();
        set_time(11, 22, 33, 44);
        make_expected(11, 22, 33, 44);
        pulse_req(1'b1, 1'b1);
        wait_quiet(1000);
        compare_q("f13_post_rst", q_13, exp_13);
        compare_q("f12_post_rst", q_12, exp_12);

        // uart_tx that never raises busy: timeout drives each byte
        clear_caps();
        no_busy = 1'b1;
        set_time(23, 45, 1, 99);
        make_expected(23, 45, 1, 99);
        pulse_req(1'b1, 1'b1);
        wait_quiet(1000);
        compare_q("f13_nobusy", q_13, exp_13);
        compare_q("f12_nobusy", q_12, exp_12);
        for (int i = 1; i < start_cyc_13.size(); i++)
            check_val($sformatf("timeout_interval[%0d]", i),
                      32'(start_cyc_13[i] - start_cyc_13[i-1]), 32'd6);
        no_busy = 1'b0;

        // Random times, including centiseconds above 99
        for (int t = 0; t < 6; t++) begin
            clear_caps();
            h = $urandom_range(23, 0);
            m = $urandom_range(59, 0);
            s = $urandom_range(59, 0);
            c = $urandom_range(127, 0);
            set_time(h, m, s, c);
            make_expected(h, m, s, c);
            pulse_req(1'b1, 1'b1);
            set_time($urandom_range(23, 0), $urandom_range(59, 0),
                     $urandom_range(59, 0), $urandom_range(127, 0));
            wait_quiet(1000);
            compare_q($sformatf("f13_rand%0d", t), q_13, exp_13);
            compare_q($sformatf("f12_rand%0d", t), q_12, exp_12);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
